// File: rtl/rotate_kick_unit_pkg.sv
// rotate_kick_unit_pkg: rotation direction codes, kick offset table and FSM state encoding
package rotate_kick_unit_pkg;
    localparam logic [1:0] DIR_CW   = 2'd0;
    localparam logic [1:0] DIR_CCW  = 2'd1;
    localparam logic [1:0] DIR_180  = 2'd2;
    localparam logic [1:0] DIR_HOLD = 2'd3;
    localparam logic signed [3:0] KICK_DX [4] = '{4'sd0, -4'sd1, 4'sd1, -4'sd2};
    typedef enum logic [1:0] {ST_IDLE, ST_ROT, ST_CHECK, ST_DONE} state_t;
endpackage

// File: rtl/rotate_kick_unit_if.sv
// rotate_kick_unit_if: request/result handshake plus board row-read port
interface rotate_kick_unit_if #(
    parameter int N       = 4,
    parameter int BOARD_W = 10,
    parameter int XW      = 5,
    parameter int YW      = 5
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_dir;
    logic [0:N*N-1]     float_in;
    logic [XW-1:0]      pos_x;
    logic [YW-1:0]      pos_y;
    logic [YW-1:0]      row_addr;
    logic [BOARD_W-1:0] row_data;
    logic               done;
    logic               ok;
    logic [0:N*N-1]     new_float;
    logic [XW-1:0]      new_x;
    logic [YW-1:0]      new_y;
    modport master (
        output req_valid, req_dir, float_in, pos_x, pos_y, row_data,
        input  req_ready, row_addr, done, ok, new_float, new_x, new_y
    );
    modport slave (
        input  req_valid, req_dir, float_in, pos_x, pos_y, row_data,
        output req_ready, row_addr, done, ok, new_float, new_x, new_y
    );
endinterface

// File: rtl/rotate_kick_unit_rotate_mask.sv
// rotate_kick_unit_rotate_mask: combinational NxN mask rotator (CW, CCW, 180, hold)
module rotate_kick_unit_rotate_mask
    import rotate_kick_unit_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [0:N*N-1] mask,
    input  logic [1:0]     dir,
    output logic [0:N*N-1] rotated
);
    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            assign rotated[r*N+c] = dir == DIR_CW  ? mask[(N-1-c)*N+r] :
                                    dir == DIR_CCW ? mask[c*N+N-1-r] :
                                    dir == DIR_180 ? mask[(N-1-r)*N+N-1-c] : mask[r*N+c];
        end
    end
endmodule

// File: rtl/rotate_kick_unit.sv
// rotate_kick_unit: rotates the falling piece and searches the kick table for a
// collision-free placement using a pipelined 1-cycle-latency board row read.
module rotate_kick_unit
    import rotate_kick_unit_pkg::*;
#(
    parameter int N       = 4,
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int KICKS   = 4
) (
    input logic              clk,
    input logic              rst_n,
    rotate_kick_unit_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    state_t                state, state_n;
    logic [1:0]            dir;
    logic [0:N*N-1]        flt, rot, rot_c;
    logic [XW-1:0]         px, res_x;
    logic [YW-1:0]         py;
    logic [CW-1:0]         cnt, r;
    logic [1:0]            kidx;
    logic                  hit, res_ok, row_hit, last, pass;
    logic signed [XW+1:0]  dx;
    logic [YW:0]           row_y;
    logic [N-1:0]          col_hit;

    rotate_kick_unit_rotate_mask #(.N(N)) u_rot (.mask(flt), .dir(dir), .rotated(rot_c));

    assign bus.req_ready = state == ST_IDLE;
    assign bus.row_addr  = py + YW'(cnt);
    assign dx    = dir == DIR_CCW ? -(XW+2)'(KICK_DX[kidx]) : (XW+2)'(KICK_DX[kidx]);
    // row_data in count cycle cnt belongs to the row addressed one cycle earlier
    assign r     = cnt - 1'b1;
    assign row_y = {1'b0, py} + (YW+1)'(r);

    for (genvar c = 0; c < N; c++) begin : g_col
        logic signed [XW+1:0] x;
        logic [BOARD_W-1:0]   sh;
        assign x  = $signed({2'b00, px}) + dx + (XW+2)'(c);
        assign sh = bus.row_data >> x;
        assign col_hit[c] = rot[r*N+c] && (x < 0 || x >= BOARD_W || row_y >= BOARD_H || sh[0]);
    end

    assign row_hit = state == ST_CHECK && cnt != '0 && |col_hit;
    assign last    = state == ST_CHECK && cnt == CW'(N);
    assign pass    = !(hit || row_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == ST_IDLE && bus.req_valid) state_n = ST_ROT;
        if (state == ST_ROT) state_n = ST_CHECK;
        if (last && (pass || kidx == 2'(KICKS - 1))) state_n = ST_DONE;
        if (state == ST_DONE) state_n = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir           <= '0;
            flt           <= '0;
            px            <= '0;
            py            <= '0;
            rot           <= '0;
            cnt           <= '0;
            kidx          <= '0;
            hit           <= 1'b0;
            res_ok        <= 1'b0;
            res_x         <= '0;
            bus.done      <= 1'b0;
            bus.ok        <= 1'b0;
            bus.new_float <= '0;
            bus.new_x     <= '0;
            bus.new_y     <= '0;
        end else begin
            bus.done <= state == ST_DONE;
            if (bus.req_ready && bus.req_valid) begin
                dir <= bus.req_dir;
                flt <= bus.float_in;
                px  <= bus.pos_x;
                py  <= bus.pos_y;
            end
            if (state == ST_ROT) begin
                rot  <= rot_c;
                cnt  <= '0;
                kidx <= '0;
                hit  <= 1'b0;
            end
            if (state == ST_CHECK) begin
                cnt <= last ? '0 : cnt + 1'b1;
                hit <= !last && (hit || row_hit);
                if (last) begin
                    kidx   <= kidx + 1'b1;
                    res_ok <= pass;
                    res_x  <= px + XW'(dx);
                end
            end
            if (state == ST_DONE) begin
                bus.ok        <= res_ok;
                bus.new_float <= res_ok ? rot : flt;
                bus.new_x     <= res_ok ? res_x : px;
                bus.new_y     <= py;
            end
        end
    end
endmodule

// File: tb/tb_rotate_kick_unit.sv
// tb_rotate_kick_unit: directed vectors into a scoreboard queue; a monitor pops
// and compares result fields and accept-to-done latency on every done pulse.
module tb_rotate_kick_unit;
    import rotate_kick_unit_pkg::*;

    typedef struct {
        logic        ok;
        logic [15:0] flt;
        logic [4:0]  x;
        logic [4:0]  y;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rotate_kick_unit_if #(.N(4), .BOARD_W(10), .XW(5), .YW(5)) bus();
    rotate_kick_unit #(.N(4), .BOARD_W(10), .BOARD_H(20), .XW(5), .YW(5), .KICKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    exp_t       q[$];
    exp_t       e;
    logic [9:0] board [32];
    int cyc = 0, checks = 0, errors = 0, dones = 0, sent = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.row_data <= board[bus.row_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            dones++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("ok", bus.ok, e.ok);
                chk("new_float", bus.new_float, e.flt);
                chk("new_x", bus.new_x, e.x);
                chk("new_y", bus.new_y, e.y);
                chk("latency", cyc, e.t);
            end
        end
    end

    task automatic clear_board(input logic [9:0] v);
        for (int i = 0; i < 32; i++) board[i] = v;
    endtask

    task automatic send(input logic [1:0] dir, input logic [15:0] flt, input logic [4:0] x,
                        input logic [4:0] y, input logic eok, input logic [15:0] eflt,
                        input logic [4:0] ex, input int lat, input bit push);
        int   n = 0;
        exp_t it;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        bus.req_valid = 1'b1;
        bus.req_dir   = dir;
        bus.float_in  = flt;
        bus.pos_x     = x;
        bus.pos_y     = y;
        if (push) begin
            it.ok = eok; it.flt = eflt; it.x = ex; it.y = y; it.t = cyc + 1 + lat;
            q.push_back(it);
            sent++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout pending=%0d required=0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, bus.req_ready, 1);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_ok"}, bus.ok, 0);
        chk({tag, "_float"}, bus.new_float, 0);
        chk({tag, "_x"}, bus.new_x, 0);
        chk({tag, "_y"}, bus.new_y, 0);
        chk({tag, "_row_addr"}, bus.row_addr, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_dir   = 2'd0;
        bus.float_in  = '0;
        bus.pos_x     = '0;
        bus.pos_y     = '0;
        clear_board(10'h000);
        #1;
        chk_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(DIR_CW, 16'h0E40, 5'd3, 5'd5, 1'b1, 16'h2620, 5'd3, 7, 1'b1);
        drain();

        // busy-time request with different inputs must be dropped entirely
        send(DIR_CW, 16'h2222, 5'd8, 5'd0, 1'b1, 16'h00F0, 5'd6, 22, 1'b1);
        repeat (6) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_dir   = DIR_HOLD;
        bus.float_in  = 16'hFFFF;
        bus.pos_x     = 5'd1;
        bus.pos_y     = 5'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();

        clear_board(10'h3FF);
        send(DIR_CCW, 16'h0E40, 5'd3, 5'd5, 1'b0, 16'h0E40, 5'd3, 22, 1'b1);
        drain();
        clear_board(10'h000);

        send(DIR_HOLD, 16'h0660, 5'd8, 5'd18, 1'b0, 16'h0660, 5'd8, 22, 1'b1);
        send(DIR_HOLD, 16'h0660, 5'd7, 5'd17, 1'b1, 16'h0660, 5'd7, 7, 1'b1);
        send(DIR_HOLD, 16'h0660, 5'd8, 5'd17, 1'b1, 16'h0660, 5'd7, 12, 1'b1);
        send(DIR_180, 16'h8E00, 5'd0, 5'd0, 1'b1, 16'h0071, 5'd0, 7, 1'b1);
        send(DIR_180, 16'h0E20, 5'd0, 5'd0, 1'b1, 16'h0470, 5'd0, 7, 1'b1);
        send(DIR_CCW, 16'h8E00, 5'd0, 5'd0, 1'b1, 16'h044C, 5'd0, 7, 1'b1);
        drain();

        board[6] = 10'h010;
        send(DIR_CW, 16'h0E40, 5'd3, 5'd5, 1'b1, 16'h2620, 5'd4, 17, 1'b1);
        drain();
        clear_board(10'h000);

        // CCW mirrors the kick table, so the +1 candidate is tried second
        board[3] = 10'h001;
        send(DIR_CCW, 16'h8E00, 5'd0, 5'd0, 1'b1, 16'h044C, 5'd1, 12, 1'b1);
        drain();
        clear_board(10'h000);

        board[10] = 10'h001;
        send(DIR_HOLD, 16'h8888, 5'd0, 5'd10, 1'b1, 16'h8888, 5'd1, 17, 1'b1);
        drain();
        clear_board(10'h000);

        send(DIR_CW, 16'h2222, 5'd8, 5'd0, 1'b0, 16'h0000, 5'd0, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_idle_ready", bus.req_ready, 1);

        send(DIR_CW, 16'h0E40, 5'd3, 5'd5, 1'b1, 16'h2620, 5'd3, 7, 1'b1);
        drain();

        chk("done_count", dones, sent);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
